key_sw_device: RTL and testbench

Memory-mapped input responder for the single-cycle CPU's data bus. It synchronizes and debounces the board push-buttons (KEY) and slide switches (SW), and serves debounced state plus sticky ready/overrun status to CPU loads. It also accepts control-register writes from CPU stores. It sits beside DataMemory on the data bus: DataMemory selects this block's read data whenever `hit` is asserted.

---
 rtl/key_sw_device_if.sv | 22 ++
 rtl/key_sw_device.sv | 131 +++++++++++++
 tb/tb_key_sw_device.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/key_sw_device_if.sv
// Data-bus view of key_sw_device: CPU load/store strobes, address, store data,
// and the combinational read-data/hit return path.
interface key_sw_device_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             rd_en;
    logic             wrt_en;
    logic [DBITS-1:0] data_in;
    logic [DBITS-1:0] data_out;
    logic             hit;

    modport master (
        output addr, rd_en, wrt_en, data_in,
        input  data_out, hit
    );

    modport slave (
        input  addr, rd_en, wrt_en, data_in,
        output data_out, hit
    );
endinterface

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW responder: synchronizes and debounces both input banks
// and exposes debounced state plus sticky ready/overrun status to CPU loads.

module key_sw_debounce #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic         evt
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  sync2_d;
    logic [CW-1:0] cnt;

    // Acceptance is combinational so stable and the status bits move on the same edge.
    assign evt = (sync2 == sync2_d) && (sync2 != stable) && (cnt == CNT_MAX);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes the synchronizer chain and counter rules order-independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
            stable  <= '0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            sync2_d <= sync2;
            if (sync2 != sync2_d) begin
                cnt <= '0;
            end else if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module key_sw_device #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    key_sw_device_if.slave        bus,
    input  logic [3:0]            KEY,
    input  logic [9:0]            SW
);
    logic [3:0] key_stable;
    logic [9:0] sw_stable;
    logic       key_evt;
    logic       sw_evt;
    logic       key_ready, key_overrun;
    logic       sw_ready, sw_overrun;

    key_sw_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (~KEY),
        .stable (key_stable),
        .evt    (key_evt)
    );

    key_sw_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk    (clk),
        .reset  (reset),
        .raw    (SW),
        .stable (sw_stable),
        .evt    (sw_evt)
    );

    logic sel_kdata, sel_sdata, sel_kctrl, sel_sctrl;
    assign sel_kdata = (bus.addr == ADDR_KDATA);
    assign sel_sdata = (bus.addr == ADDR_SDATA);
    assign sel_kctrl = (bus.addr == ADDR_KCTRL);
    assign sel_sctrl = (bus.addr == ADDR_SCTRL);
    assign bus.hit   = sel_kdata | sel_sdata | sel_kctrl | sel_sctrl;

    // Only bit 2 of store data is meaningful (overrun clear).
    logic unused_data_bits;
    assign unused_data_bits = ^{bus.data_in[DBITS-1:3], bus.data_in[1:0]};

    logic key_rd, sw_rd, key_clr, sw_clr;
    assign key_rd  = bus.rd_en && sel_kdata;
    assign sw_rd   = bus.rd_en && sel_sdata;
    assign key_clr = bus.wrt_en && sel_kctrl && !bus.data_in[2];
    assign sw_clr  = bus.wrt_en && sel_sctrl && !bus.data_in[2];

    // A change event beats a same-cycle data read (new data wins, no overrun)
    // and beats a same-cycle overrun clear (event wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            key_ready   <= 1'b0;
            key_overrun <= 1'b0;
            sw_ready    <= 1'b0;
            sw_overrun  <= 1'b0;
        end else begin
            key_ready   <= key_evt | (key_ready & ~key_rd);
            key_overrun <= (key_evt & key_ready & ~key_rd) | (key_overrun & ~key_clr);
            sw_ready    <= sw_evt | (sw_ready & ~sw_rd);
            sw_overrun  <= (sw_evt & sw_ready & ~sw_rd) | (sw_overrun & ~sw_clr);
        end
    end

    // NOTE: data_out gets a default first so the unmatched-address path
    // cannot infer a latch.
    always_comb begin
        bus.data_out = '0;
        if (sel_kdata)      bus.data_out = DBITS'(key_stable);
        else if (sel_sdata) bus.data_out = DBITS'(sw_stable);
        else if (sel_kctrl) bus.data_out = DBITS'({key_overrun, 1'b0, key_ready});
        else if (sel_sctrl) bus.data_out = DBITS'({sw_overrun, 1'b0, sw_ready});
    end
endmodule

// File: tb/tb_key_sw_device.sv
// Directed bench for key_sw_device with DEBOUNCE_CYCLES=4; expected register
// values go through a scoreboard queue and are checked with immediate assertions.
module tb_key_sw_device;
    localparam int          D     = 4;
    localparam logic [31:0] KDATA = 32'hF0000010;
    localparam logic [31:0] SDATA = 32'hF0000014;
    localparam logic [31:0] KCTRL = 32'hF0000110;
    localparam logic [31:0] SCTRL = 32'hF0000114;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;

    key_sw_device_if #(.DBITS(32)) bus ();

    key_sw_device #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .KEY   (KEY),
        .SW    (SW)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register peek: no side effects, compared against the scoreboard entry.
    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        bus.addr  = a;
        bus.rd_en = 1'b0;
        sb.push_back('{tag, exp});
        #1;
        e = sb.pop_front();
        check(e.tag, bus.data_out, e.value);
    endtask

    task automatic peek_hit(input string tag, input logic [31:0] a, input logic exp);
        exp_t e;
        bus.addr = a;
        sb.push_back('{tag, {31'b0, exp}});
        #1;
        e = sb.pop_front();
        check(e.tag, {31'b0, bus.hit}, e.value);
    endtask

    task automatic load(input logic [31:0] a);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr    = a;
        bus.data_in = d;
        bus.wrt_en  = 1'b1;
        tick();
        bus.wrt_en  = 1'b0;
    endtask

    initial begin
        bus.addr    = '0;
        bus.rd_en   = 1'b0;
        bus.wrt_en  = 1'b0;
        bus.data_in = '0;
        KEY         = 4'hF;
        SW          = '0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and address decode
        peek("rst_kdata", KDATA, 32'h0);
        peek("rst_sdata", SDATA, 32'h0);
        peek("rst_kctrl", KCTRL, 32'h0);
        tick();
        peek("rst_sctrl", SCTRL, 32'h0);
        peek_hit("hit_kdata", KDATA, 1'b1);
        peek_hit("hit_sdata", SDATA, 1'b1);
        tick();
        peek_hit("hit_kctrl", KCTRL, 1'b1);
        peek_hit("hit_sctrl", SCTRL, 1'b1);
        peek_hit("hit_none", 32'hF0000000, 1'b0);
        peek("none_data", 32'hF0000000, 32'h0);

        // Switch change latency: accepted at edge D+3
        SW = 10'h2A5;
        for (int e = 1; e <= D + 2; e++) begin
            tick();
            peek($sformatf("sdata_edge%0d", e), SDATA, 32'h0);
        end
        tick();
        peek("sdata_edge7", SDATA, 32'h2A5);
        peek("sctrl_edge7", SCTRL, 32'h1);

        // Short key pulse is filtered out
        KEY = 4'hD;
        for (int e = 0; e < D; e++) tick();
        KEY = 4'hF;
        for (int e = 0; e < 12; e++) tick();
        peek("pulse_kdata", KDATA, 32'h0);
        peek("pulse_kctrl", KCTRL, 32'h0);

        // Second accepted change without a read sets overrun
        SW = 10'h0F0;
        for (int e = 0; e < 10; e++) tick();
        peek("ovr_sctrl", SCTRL, 32'h5);
        peek("ovr_sdata", SDATA, 32'h0F0);
        load(SDATA);
        peek("ovr_after_load", SCTRL, 32'h4);
        store(SCTRL, 32'h0);
        peek("ovr_clear", SCTRL, 32'h0);

        SW = 10'h001;
        for (int e = 0; e < 10; e++) tick();
        SW = 10'h002;
        for (int e = 0; e < 10; e++) tick();
        peek("ovr2_sctrl", SCTRL, 32'h5);
        load(SDATA);
        store(SCTRL, 32'h4);
        peek("ovr_write1_ignored", SCTRL, 32'h4);
        store(SCTRL, 32'hFFFF_FFFB);
        peek("ovr_clear_bit2", SCTRL, 32'h0);
        store(SDATA, 32'h0);
        peek("sdata_store_ignored", SDATA, 32'h002);

        // KDATA load in the same cycle as a key change event
        KEY = 4'hE;
        for (int e = 1; e <= D + 2; e++) tick();
        bus.addr  = KDATA;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        peek("coincide_kctrl", KCTRL, 32'h1);
        peek("coincide_kdata", KDATA, 32'h1);
        load(KDATA);
        peek("kdata_load_clears", KCTRL, 32'h0);

        // Reset in mid-count discards the pending switch change
        SW = 10'h001;
        for (int e = 0; e < 5; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        peek("midrst_sctrl", SCTRL, 32'h0);
        peek("midrst_sdata", SDATA, 32'h0);
        for (int e = 1; e <= D + 2; e++) begin
            tick();
            peek($sformatf("redeb_edge%0d", e), SDATA, 32'h0);
        end
        tick();
        peek("redeb_sdata", SDATA, 32'h001);
        peek("redeb_sctrl", SCTRL, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
